fib_req_scheduler: RTL
======================

FIB_REQ_SCHEDULER -- requirements
Module: fib_req_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, 6, width of requested index.
REQ-002 SHALL have parameter MAX_IDX, 46, largest legal index (result fits 32 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  requester n has a pending request.
REQ-006 SHALL have ports req0_idx / req1_idx  input  IDX_W each  number of generator steps requested.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-008 SHALL have port rsp_valid  output  1  response held.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_data  output  32  captured generator value.
REQ-011 SHALL have port rsp_id  output  1  requester the response belongs to.
REQ-012 SHALL have port rsp_err  output  1  index rejected; rsp_data 0.
REQ-013 SHALL have port gen_rst  output  1  drives generator asynchronous reset.
REQ-014 SHALL have port gen_enable  output  1  drives generator step enable.
REQ-015 SHALL have port gen_fib  input  32  generator current output.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, RUN, CAPT, RESP.
REQ-017 IDLE: at most one readyN high, only for a valid requester; none high in other states.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; single valid -> grant it.
REQ-019 Handshake in IDLE SHALL latch idx and id, go to CLR (or RESP with error, REQ-029).
REQ-020 CLR: one cycle, gen_rst=1, gen_enable=0, step counter loaded with idx.
REQ-021 CLR -> RUN if idx>0, else CAPT.
REQ-022 RUN: gen_enable=1 exactly idx consecutive cycles, counter decrements; last cycle -> CAPT.
REQ-023 CAPT: gen_enable=0, gen_fib registered into rsp_data, -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err stable until rsp_valid&rsp_ready; then -> IDLE.
REQ-025 Latency SHALL be idx+3 cycles from request handshake to first rsp_valid cycle.
REQ-026 Next request SHALL be accepted no earlier than cycle after response handshake.
REQ-027 gen_enable SHALL never be high in IDLE, CLR, CAPT, RESP.
REQ-028 Resulting values SHALL equal generator output after idx steps from reset: 0->0, 1->1, 2->2, 3->3, 4->5, 10->89, 46->2971215073.

Reset
REQ-029 rst high SHALL asynchronously force IDLE, round-robin pointer so req0 wins first tie, counter 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, gen_enable 0, req ready 0.
REQ-030 gen_rst SHALL be high whenever rst is high or state is CLR.
REQ-031 rst mid-RUN/RESP SHALL abandon the in-flight request with no response.

Configuration
REQ-032 Macro FIB_IDX_RANGE_CHECK_EN defined: idx>MAX_IDX accepted, skips CLR/RUN, goes to RESP next cycle with rsp_err=1, rsp_data=0 (latency 1).
REQ-033 Macro undefined: no range check, rsp_err tied 0, any idx run normally (result wraps modulo 2^32).

Verification
REQ-034 req0 idx=10, rsp_ready=1 -> rsp_valid 13 cycles after handshake, rsp_data=89, rsp_id=0, 10 gen_enable cycles.
REQ-035 req0 and req1 valid same cycle, idx 3 and 4, repeat -> grants 0,1,0,1; data 3 then 5.
REQ-036 idx=0 -> one gen_rst cycle, no gen_enable, rsp_data=0 at latency 3.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> outputs stable, no ready, no gen_enable.
REQ-038 rst pulse during RUN of idx=20 -> IDLE, gen_rst high, no response; next idx=4 -> 5.
REQ-039 With FIB_IDX_RANGE_CHECK_EN, idx=50 -> rsp_err=1, rsp_data=0 one cycle after handshake; without it, no error and generator runs 50 steps.

Source files
------------

// File: rtl/fib_req_scheduler.sv
// -----------------------------------------------------------------------------
// fib_req_scheduler
//
// Purpose: arbitrates between two requesters that each ask for the value of an
// external Fibonacci-style generator after a given number of steps. A granted
// request resets the generator, steps it idx times, captures its output and
// holds it as a response until the consumer takes it. Only one request is in
// flight at a time; ties between requesters are broken round-robin.
//
// Optional feature (compile-time macro FIB_IDX_RANGE_CHECK_EN):
//   defined   - an idx above MAX_IDX is accepted but answered one cycle later
//               with rsp_err=1 and rsp_data=0, without touching the generator.
//   undefined - no range check; rsp_err is tied low and any idx runs normally.
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   req0_valid   in   requester 0 has a pending request
//   req0_idx     in   number of generator steps requested by requester 0
//   req0_ready   out  requester 0 request accepted this cycle (valid&ready)
//   req1_valid   in   requester 1 has a pending request
//   req1_idx     in   number of generator steps requested by requester 1
//   req1_ready   out  requester 1 request accepted this cycle (valid&ready)
//   rsp_valid    out  response held
//   rsp_ready    in   consumer accepts response
//   rsp_data     out  captured generator value
//   rsp_id       out  requester the response belongs to
//   rsp_err      out  index rejected (rsp_data is 0)
//   gen_rst      out  generator asynchronous reset
//   gen_enable   out  generator step enable
//   gen_fib      in   generator current output
// -----------------------------------------------------------------------------
module fib_req_scheduler #(
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned MAX_IDX = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IDX_W-1:0] req0_idx,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDX_W-1:0] req1_idx,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             gen_rst,
  output logic             gen_enable,
  input  logic [31:0]      gen_fib
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StCapt,
    StResp
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [IDX_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_id,    w_id_nxt;
  logic             r_last,  w_last_nxt;   // requester granted most recently
  logic [31:0]      r_data,  w_data_nxt;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_rdy0;
  logic             w_rdy1;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: on a tie the requester not granted last wins.
  // ---------------------------------------------------------------------------
  assign w_gnt1    = req1_valid & (~req0_valid | ~r_last);
  assign w_gnt0    = req0_valid & ~w_gnt1;
  assign w_sel_idx = w_gnt1 ? req1_idx : req0_idx;

`ifdef FIB_IDX_RANGE_CHECK_EN
  logic r_err, w_err_nxt;
  logic w_idx_over;

  assign w_idx_over = 32'(w_sel_idx) > MAX_IDX;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
`ifdef FIB_IDX_RANGE_CHECK_EN
    w_err_nxt   = r_err;
`endif
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    gen_enable  = 1'b0;
    rsp_valid   = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_rdy0 = w_gnt0;
        w_rdy1 = w_gnt1;
        if (w_gnt0 || w_gnt1) begin
          w_idx_nxt   = w_sel_idx;
          w_id_nxt    = w_gnt1;
          w_last_nxt  = w_gnt1;
          w_state_nxt = StClr;
`ifdef FIB_IDX_RANGE_CHECK_EN
          w_err_nxt   = 1'b0;
          if (w_idx_over) begin
            // Rejected index: answer straight away, generator untouched.
            w_err_nxt   = 1'b1;
            w_data_nxt  = 32'd0;
            w_state_nxt = StResp;
          end
`endif
        end
      end

      StClr: begin
        // gen_rst is asserted for this whole cycle (see below).
        w_cnt_nxt   = r_idx;
        w_state_nxt = (r_idx != '0) ? StRun : StCapt;
      end

      StRun: begin
        gen_enable = 1'b1;
        w_cnt_nxt  = r_cnt - IDX_W'(1);
        if (r_cnt == IDX_W'(1)) begin
          w_state_nxt = StCapt;
        end
      end

      StCapt: begin
        w_data_nxt  = gen_fib;
        w_state_nxt = StResp;
      end

      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;  // makes requester 0 win the first tie
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
    end
  end

`ifdef FIB_IDX_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;

  // MAX_IDX is only consulted by the range check; the empty block keeps the
  // parameter referenced in builds without it.
  if (MAX_IDX == 0) begin : g_max_idx_ref
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // State is already IDLE during reset, so readies must be masked by rst itself.
  assign req0_ready = w_rdy0 & ~rst;
  assign req1_ready = w_rdy1 & ~rst;
  assign rsp_data   = r_data;
  assign rsp_id     = r_id;
  assign gen_rst    = rst | (r_state == StClr);

endmodule
